// File: rtl/arm_pipe_pkg.sv
// Shared pipeline types and helpers.
// Select-width function and 32-bit operand type.
package arm_pipe_pkg;

  localparam int OPERAND_W = 32;

  typedef logic [OPERAND_W-1:0] operand_t;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/operand_mux_pipe_mux_nx1.sv
// Combinational NUM_IN-to-1 selector.
// Flags selects that index past the last input.
module mux_nx1
  import arm_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        sel_data,
  output logic                    sel_oor
);

  // Out-of-range selects yield zero
  always_comb begin
    sel_data = '0;
    sel_oor  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_oor  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/operand_mux_pipe.sv
// Registered operand selector with skid buffer.
// Feeds the execute stage with valid/ready flow control.
module operand_mux_pipe
  import arm_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  logic [WIDTH-1:0] mux_data;
  logic             mux_oor;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;

  logic in_fire;
  logic out_fire;
  logic load_out;
  logic drain;
  logic go_idle;
  logic load_skid;

  mux_nx1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .in_data  (in_data),
    .sel      (in_sel),
    .sel_data (mux_data),
    .sel_oor  (mux_oor)
  );

  assign in_ready = !skid_valid;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Mutually exclusive storage moves
  assign load_out  = in_fire &
                     (!out_valid | (out_fire & !skid_valid));
  assign drain     = out_fire & skid_valid;
  assign go_idle   = out_fire & !skid_valid & !in_fire;
  assign load_skid = in_fire & out_valid & !out_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      sel_err    <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      if (in_fire & mux_oor)
        sel_err <= 1'b1;
      unique case (1'b1)
        load_out: begin
          out_data  <= mux_data;
          out_valid <= 1'b1;
        end
        drain: begin
          out_data   <= skid_data;
          skid_valid <= 1'b0;
        end
        go_idle: begin
          out_valid <= 1'b0;
        end
        load_skid: begin
          skid_data  <= mux_data;
          skid_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
